// File: rtl/multicycle_control_pkg.sv
// Shared definitions for the multicycle MIPS control unit: field widths,
// opcode constants, FSM state encodings and opcode class encodings.
package multicycle_control_pkg;

  localparam int OPCODE_W = 6;
  localparam int FUNCT_W  = 6;

  localparam logic [5:0] OP_R    = 6'h00;
  localparam logic [5:0] OP_ADDI = 6'h08;
  localparam logic [5:0] OP_SLTI = 6'h0A;
  localparam logic [5:0] OP_ANDI = 6'h0C;
  localparam logic [5:0] OP_ORI  = 6'h0D;
  localparam logic [5:0] OP_LW   = 6'h23;
  localparam logic [5:0] OP_SW   = 6'h2B;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_FETCH  = 3'd1;
  localparam logic [2:0] ST_DECODE = 3'd2;
  localparam logic [2:0] ST_EXEC   = 3'd3;
  localparam logic [2:0] ST_MEM    = 3'd4;
  localparam logic [2:0] ST_WB     = 3'd5;

  typedef enum logic [2:0] {
    CLS_RTYPE   = 3'd0,
    CLS_IMM     = 3'd1,
    CLS_LOAD    = 3'd2,
    CLS_STORE   = 3'd3,
    CLS_ILLEGAL = 3'd4
  } op_class_e;

endpackage

// File: rtl/multicycle_control_opcode_class.sv
// Combinational opcode -> instruction class decode, shared by the control
// FSM and, later, the hazard logic.
module opcode_class
  import multicycle_control_pkg::*;
#(
  parameter int OPCODE_WIDTH = OPCODE_W
) (
  input  logic [OPCODE_WIDTH-1:0] opcode_i,
  output op_class_e               class_o
);

  always_comb begin
    class_o = CLS_ILLEGAL;
    if (opcode_i == OPCODE_WIDTH'(OP_R))
      class_o = CLS_RTYPE;
    else if (opcode_i == OPCODE_WIDTH'(OP_ADDI) || opcode_i == OPCODE_WIDTH'(OP_SLTI) ||
             opcode_i == OPCODE_WIDTH'(OP_ANDI) || opcode_i == OPCODE_WIDTH'(OP_ORI))
      class_o = CLS_IMM;
    else if (opcode_i == OPCODE_WIDTH'(OP_LW))
      class_o = CLS_LOAD;
    else if (opcode_i == OPCODE_WIDTH'(OP_SW))
      class_o = CLS_STORE;
  end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle sequencing FSM: steps each instruction through F/D/E/M/W,
// inserts memory wait states, and keeps sticky error flags and a retire count.
module multicycle_control
  import multicycle_control_pkg::*;
#(
  parameter int OPCODE_WIDTH = OPCODE_W,
  parameter int CNT_WIDTH    = 16,
  parameter int MEM_TIMEOUT  = 15
) (
  input  logic                    c_clk,
  input  logic                    c_rst,
  input  logic                    c_i_start,
  input  logic [OPCODE_WIDTH-1:0] c_i_opcode,
  input  logic                    c_i_mem_ready,
  output logic                    c_o_ce,
  output logic                    c_o_reg_dst,
  output logic                    c_o_reg_write,
  output logic                    c_o_alu_src,
  output logic                    c_o_mem_read,
  output logic                    c_o_mem_write,
  output logic                    c_o_mem_to_reg,
  output logic                    c_o_busy,
  output logic [2:0]              c_o_state,
  output logic                    c_o_illegal,
  output logic                    c_o_timeout,
  output logic [CNT_WIDTH-1:0]    c_o_instr_count
);

  // Timeout fires on the wait cycle that would bring the count to MEM_TIMEOUT.
  localparam logic [7:0] WAIT_LAST = 8'(MEM_TIMEOUT - 1);

  logic [2:0]           state_q, state_d, next_fetch;
  op_class_e            class_q, class_d, dec_class;
  logic [7:0]           wait_q, wait_d;
  logic                 illegal_q, illegal_d;
  logic                 timeout_q, timeout_d;
  logic [CNT_WIDTH-1:0] count_q;
  logic                 retire;
  logic                 in_dp;

  opcode_class #(.OPCODE_WIDTH(OPCODE_WIDTH)) u_opcode_class (
    .opcode_i (c_i_opcode),
    .class_o  (dec_class)
  );

  assign next_fetch = c_i_start ? ST_FETCH : ST_IDLE;

  always_comb begin
    state_d   = state_q;
    class_d   = class_q;
    wait_d    = '0;
    illegal_d = illegal_q;
    timeout_d = timeout_q;
    retire    = 1'b0;
    case (state_q)
      ST_IDLE:   if (c_i_start) state_d = ST_FETCH;
      ST_FETCH:  state_d = ST_DECODE;
      ST_DECODE: begin
        class_d = dec_class;
        if (dec_class == CLS_ILLEGAL) begin
          illegal_d = 1'b1;
          state_d   = next_fetch;
        end else begin
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: state_d = (class_q == CLS_LOAD || class_q == CLS_STORE) ? ST_MEM : ST_WB;
      ST_MEM: begin
        if (c_i_mem_ready) begin
          if (class_q == CLS_LOAD) begin
            state_d = ST_WB;
          end else begin
            retire  = 1'b1;
            state_d = next_fetch;
          end
        end else if (wait_q == WAIT_LAST) begin
          timeout_d = 1'b1;
          state_d   = ST_IDLE;
        end else begin
          wait_d = wait_q + 8'd1;
        end
      end
      ST_WB: begin
        retire  = 1'b1;
        state_d = next_fetch;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge c_clk or posedge c_rst) begin
    if (c_rst) begin
      state_q   <= ST_IDLE;
      class_q   <= CLS_ILLEGAL;
      wait_q    <= '0;
      illegal_q <= 1'b0;
      timeout_q <= 1'b0;
      count_q   <= '0;
    end else begin
      state_q   <= state_d;
      class_q   <= class_d;
      wait_q    <= wait_d;
      illegal_q <= illegal_d;
      timeout_q <= timeout_d;
      count_q   <= count_q + CNT_WIDTH'(retire);
    end
  end

  // Steering lines follow the latched class only while the datapath is active.
  assign in_dp = (state_q == ST_EXEC) || (state_q == ST_MEM) || (state_q == ST_WB);

  assign c_o_ce          = (state_q == ST_FETCH);
  assign c_o_reg_dst     = in_dp && (class_q == CLS_RTYPE);
  assign c_o_alu_src     = in_dp && (class_q inside {CLS_IMM, CLS_LOAD, CLS_STORE});
  assign c_o_mem_to_reg  = in_dp && (class_q == CLS_LOAD);
  assign c_o_mem_read    = (state_q == ST_MEM) && (class_q == CLS_LOAD);
  assign c_o_mem_write   = (state_q == ST_MEM) && (class_q == CLS_STORE);
  assign c_o_reg_write   = (state_q == ST_WB);
  assign c_o_busy        = (state_q != ST_IDLE);
  assign c_o_state       = state_q;
  assign c_o_illegal     = illegal_q;
  assign c_o_timeout     = timeout_q;
  assign c_o_instr_count = count_q;

endmodule
